// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned AddrW  = 64;
    localparam int unsigned InstrW = 32;
    localparam logic [AddrW-1:0] PcInc = 64'd4;

    typedef enum logic {
        StBoot,
        StRun
    } fetch_state_e;

    // Instructions are word-aligned; redirects drop the low two bits.
    function automatic logic [AddrW-1:0] align_pc(input logic [AddrW-1:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {PC, instruction} holding register catching the response that lands
// after decode raises stall.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [AddrW-1:0]  pc_i,
    input  logic [InstrW-1:0] instr_i,
    output logic              valid_o,
    output logic [AddrW-1:0]  pc_o,
    output logic [InstrW-1:0] instr_o
);

    logic              valid_q, valid_d;
    logic [AddrW-1:0]  pc_q, pc_d;
    logic [InstrW-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem reads, IF/ID
// register with a one-entry skid buffer for stalls and branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [AddrW-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [AddrW-1:0]  branch_target_i,
    output logic              imem_req_o,
    output logic [AddrW-1:0]  imem_addr_o,
    input  logic [InstrW-1:0] imem_data_i,
    output logic [AddrW-1:0]  pc_plus4_o,
    output logic [AddrW-1:0]  ifid_pc_o,
    output logic [InstrW-1:0] ifid_instr_o,
    output logic              ifid_valid_o,
    output logic              align_err_o
);

    fetch_state_e      state_q, state_d;
    logic              run, redirect;
    logic [AddrW-1:0]  pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [AddrW-1:0]  pend_pc_q, pend_pc_d;
    logic [AddrW-1:0]  ifid_pc_q, ifid_pc_d;
    logic [InstrW-1:0] ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              align_err_q, align_err_d;
    logic              skid_load, skid_pop, skid_valid;
    logic [AddrW-1:0]  skid_pc;
    logic [InstrW-1:0] skid_instr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        run        = (state_q == StRun);
        redirect   = run && branch_taken_i;
        imem_req_o = run && !stall_i && !branch_taken_i;
    end

    // Datapath next state; a redirect overrides stall and discards in-flight data.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = imem_req_o;
        pend_pc_d    = pend_pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        align_err_d  = align_err_q;
        skid_load    = 1'b0;
        skid_pop     = 1'b0;
        if (imem_req_o) begin
            pc_d      = pc_q + PcInc;
            pend_pc_d = pc_q;
        end
        if (redirect) begin
            pc_d         = align_pc(branch_target_i);
            ifid_valid_d = 1'b0;
            if (branch_target_i[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end else if (run) begin
            if (stall_i) begin
                skid_load = pend_q;
            end else if (skid_valid) begin
                skid_pop     = 1'b1;
                ifid_pc_d    = skid_pc;
                ifid_instr_d = skid_instr;
                ifid_valid_d = 1'b1;
            end else if (pend_q) begin
                ifid_pc_d    = pend_pc_q;
                ifid_instr_d = imem_data_i;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (redirect),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .pc_i    (pend_pc_q),
        .instr_i (imem_data_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign imem_addr_o  = pc_q;
    assign pc_plus4_o   = pc_q + PcInc;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign align_err_o  = align_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a fetch-stream queue model.
module tb_fetch_unit;

    localparam logic [63:0] RstPc = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic [63:0] plus4;
        logic        ifv;
        logic [63:0] ifpc;
        logic [31:0] ifin;
        logic        align;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [63:0] branch_target_i = '0;
    logic [31:0] imem_data_i = '0;
    logic        imem_req_o, ifid_valid_o, align_err_o;
    logic [63:0] imem_addr_o, pc_plus4_o, ifid_pc_o;
    logic [31:0] ifid_instr_o;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sb[$];
    ent_t        m_fifo[$];
    logic        m_run, m_ifv, m_align, m_last_req;
    logic [63:0] m_pc, m_ifpc, m_last_addr;
    logic [31:0] m_ifin;

    fetch_unit #(
        .RESET_PC (RstPc)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .pc_plus4_o      (pc_plus4_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_valid_o    (ifid_valid_o),
        .align_err_o     (align_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_run      = 1'b0;
        m_pc       = RstPc;
        m_ifv      = 1'b0;
        m_ifpc     = '0;
        m_ifin     = '0;
        m_align    = 1'b0;
        m_last_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_req", {63'd0, imem_req_o}, 64'd0);
        chk("rst_imem_addr", imem_addr_o, RstPc);
        chk("rst_pc_plus4", pc_plus4_o, RstPc + 64'd4);
        chk("rst_ifid_pc", ifid_pc_o, 64'd0);
        chk("rst_ifid_instr", {32'd0, ifid_instr_o}, 64'd0);
        chk("rst_ifid_valid", {63'd0, ifid_valid_o}, 64'd0);
        chk("rst_align_err", {63'd0, align_err_o}, 64'd0);
    endtask

    // Called at posedge+1: drives one cycle, queues what the DUT should show,
    // then advances the model across the coming edge.
    task automatic drive_cycle(input logic s, input logic b, input logic [63:0] t);
        exp_t e;
        ent_t ent;
        stall_i         = s;
        branch_taken_i  = b;
        branch_target_i = t;
        imem_data_i     = m_last_req ? mem_word(m_last_addr) : $urandom;
        e.req   = m_run && !s && !b;
        e.addr  = m_pc;
        e.plus4 = m_pc + 64'd4;
        e.ifv   = m_ifv;
        e.ifpc  = m_ifpc;
        e.ifin  = m_ifin;
        e.align = m_align;
        sb.push_back(e);
        m_last_req  = e.req;
        m_last_addr = m_pc;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (b) begin
            m_fifo.delete();
            m_ifv = 1'b0;
            m_pc  = {t[63:2], 2'b00};
            if (t[1:0] != 2'b00) m_align = 1'b1;
        end else if (!s) begin
            if (m_fifo.size() > 0) begin
                ent    = m_fifo.pop_front();
                m_ifv  = 1'b1;
                m_ifpc = ent.pc;
                m_ifin = ent.instr;
            end else begin
                m_ifv = 1'b0;
            end
            if (e.req) begin
                ent.pc    = m_pc;
                ent.instr = mem_word(m_pc);
                m_fifo.push_back(ent);
                m_pc = m_pc + 64'd4;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        logic [63:0] t;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)     t = {$urandom, $urandom};
            else if (r < 3) t = 64'hFFFF_FFFF_FFFF_FFF0;
            else            t = {$urandom, $urandom} & ~64'h3;
            drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_req", {63'd0, imem_req_o}, {63'd0, e.req});
            chk("imem_addr", imem_addr_o, e.addr);
            chk("pc_plus4", pc_plus4_o, e.plus4);
            chk("ifid_valid", {63'd0, ifid_valid_o}, {63'd0, e.ifv});
            chk("align_err", {63'd0, align_err_o}, {63'd0, e.align});
            if (e.ifv) begin
                chk("ifid_pc", ifid_pc_o, e.ifpc);
                chk("ifid_instr", {32'd0, ifid_instr_o}, {32'd0, e.ifin});
            end
        end
    end

    initial begin
        model_reset();
        #2;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs();
        rst_ni = 1'b1;

        // Boot, then sequential fetch across the 2^64 wrap.
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, '0);
        // Stall three cycles right after a request: response goes to the skid.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0);
        // Redirect while a response is pending.
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 64'h100);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0);
        // Redirect and stall together with the skid full.
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b1, 64'h40);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0);
        // Misaligned target sets the sticky flag.
        drive_cycle(1'b0, 1'b1, 64'h103);
        for (int i = 0; i < 3; i++) drive_cycle(i == 1, 1'b0, '0);
        // Asynchronous reset while stalled with the skid full.
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, '0);
        stall_i = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0);

        random_cycles(400);
        do_reset();
        random_cycles(400);

        @(negedge clk_i);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
